// File: rtl/maze_solve_gen.sv
// Wall-following maze solver sequencer. It alternates forward moves and
// heading changes, choosing each turn from the side-wall sensors and the
// selected affinity mode. It also keeps a move budget, a per-wait timeout
// and busy/solved/fail status.
module maze_solve_gen #(
  parameter int unsigned          HDG_WIDTH = 12,
  parameter logic [HDG_WIDTH-1:0] H_N       = 12'h000,
  parameter logic [HDG_WIDTH-1:0] H_W       = 12'h3FF,
  parameter logic [HDG_WIDTH-1:0] H_S       = 12'h7FF,
  parameter logic [HDG_WIDTH-1:0] H_E       = 12'hC00,
  parameter int unsigned          MV_CNT_W  = 10,
  parameter int unsigned          MAX_MOVES = 1000,
  parameter int unsigned          TMO_CYC   = 2**20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_md,
  input  logic [1:0]           mode,
  input  logic                 frnt_opn,
  input  logic                 lft_opn,
  input  logic                 rght_opn,
  input  logic                 mv_cmplt,
  input  logic                 sol_cmplt,
  output logic                 strt_hdng,
  output logic                 strt_mv,
  output logic [HDG_WIDTH-1:0] dsrd_hdng,
  output logic                 stp_lft,
  output logic                 stp_rght,
  output logic                 busy,
  output logic                 solved,
  output logic                 fail,
  output logic [MV_CNT_W-1:0]  mv_cnt
);

  localparam int unsigned         TMO_W    = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam bit                  TMO_EN   = (TMO_CYC != 0);
  localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);
  localparam bit                  LIM_EN   = (MAX_MOVES != 0);
  localparam logic [MV_CNT_W-1:0] MV_LIMIT = MV_CNT_W'(MAX_MOVES);

  typedef enum logic [2:0] {
    IDLE, STRT_MV, WAIT_MV, NEW_HDNG, STRT_HDNG, WAIT_HDNG, FAIL
  } state_e;

  typedef enum logic [1:0] {TURN_L, TURN_R, TURN_U} turn_e;

  state_e           state;
  logic [1:0]       mode_q;
  logic [TMO_W-1:0] tmo_cnt;

  // Heading after a turn. Any non-canonical heading recovers to north.
  function automatic logic [HDG_WIDTH-1:0] turn(input logic [HDG_WIDTH-1:0] h,
                                                input turn_e t);
    logic [HDG_WIDTH-1:0] r;
    r = H_N;
    if (h == H_N)      r = (t == TURN_L) ? H_W : (t == TURN_R) ? H_E : H_S;
    else if (h == H_W) r = (t == TURN_L) ? H_S : (t == TURN_R) ? H_N : H_E;
    else if (h == H_S) r = (t == TURN_L) ? H_E : (t == TURN_R) ? H_W : H_N;
    else if (h == H_E) r = (t == TURN_L) ? H_N : (t == TURN_R) ? H_S : H_W;
    return r;
  endfunction

  // Turn choice at a decision point, from affinity and side openings.
  function automatic turn_e pick_turn(input logic left_aff, input logic l_o,
                                      input logic r_o);
    turn_e t;
    if (left_aff) t = l_o ? TURN_L : (r_o ? TURN_R : TURN_U);
    else          t = r_o ? TURN_R : (l_o ? TURN_L : TURN_U);
    return t;
  endfunction

  assign stp_lft  = mode_q[0];
  assign stp_rght = ~mode_q[0];

  // Solver sequencer; every status/pulse output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dsrd_hdng <= H_N;
      mode_q    <= 2'b00;
      mv_cnt    <= '0;
      tmo_cnt   <= '0;
      solved    <= 1'b0;
      strt_hdng <= 1'b0;
      strt_mv   <= 1'b0;
      busy      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      strt_hdng <= 1'b0;
      strt_mv   <= 1'b0;
      if (cmd_md && (state inside {STRT_MV, WAIT_MV, NEW_HDNG, STRT_HDNG, WAIT_HDNG})) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!cmd_md) begin
              state   <= STRT_MV;
              strt_mv <= 1'b1;
              busy    <= 1'b1;
              mode_q  <= mode;
              mv_cnt  <= '0;
              solved  <= 1'b0;
            end
          end
          STRT_MV: begin
            state   <= WAIT_MV;
            tmo_cnt <= '0;
          end
          WAIT_MV: begin
            if (mv_cmplt) begin
              state <= NEW_HDNG;
              if (mv_cnt != '1) mv_cnt <= mv_cnt + 1'b1;
            end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
              state <= FAIL;
              busy  <= 1'b0;
              fail  <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          NEW_HDNG: begin
            if (sol_cmplt) begin
              state  <= IDLE;
              busy   <= 1'b0;
              solved <= 1'b1;
            end else if (LIM_EN && (mv_cnt >= MV_LIMIT)) begin
              state <= FAIL;
              busy  <= 1'b0;
              fail  <= 1'b1;
            end else if (mode_q[1] && frnt_opn) begin
              state   <= STRT_MV;
              strt_mv <= 1'b1;
            end else begin
              state     <= STRT_HDNG;
              strt_hdng <= 1'b1;
              dsrd_hdng <= turn(dsrd_hdng, pick_turn(mode_q[0], lft_opn, rght_opn));
            end
          end
          STRT_HDNG: begin
            state   <= WAIT_HDNG;
            tmo_cnt <= '0;
          end
          WAIT_HDNG: begin
            if (mv_cmplt) begin
              state   <= STRT_MV;
              strt_mv <= 1'b1;
            end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
              state <= FAIL;
              busy  <= 1'b0;
              fail  <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          FAIL: begin
            if (cmd_md) begin
              state <= IDLE;
              fail  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            fail  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_maze_solve_gen.sv
// Bench for maze_solve_gen: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_maze_solve_gen;

  localparam int unsigned MAXM = 3;
  localparam int unsigned TMO  = 16;
  localparam int unsigned CW   = 10;

  logic        clk = 1'b0;
  logic        rst, cmd_md, frnt_opn, lft_opn, rght_opn, mv_cmplt, sol_cmplt;
  logic [1:0]  mode;
  logic        strt_hdng, strt_mv, stp_lft, stp_rght, busy, solved, fail;
  logic [11:0] dsrd_hdng;
  logic [CW-1:0] mv_cnt;

  maze_solve_gen #(.HDG_WIDTH(12), .MV_CNT_W(CW), .MAX_MOVES(MAXM), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_md(cmd_md), .mode(mode), .frnt_opn(frnt_opn),
    .lft_opn(lft_opn), .rght_opn(rght_opn), .mv_cmplt(mv_cmplt), .sol_cmplt(sol_cmplt),
    .strt_hdng(strt_hdng), .strt_mv(strt_mv), .dsrd_hdng(dsrd_hdng), .stp_lft(stp_lft),
    .stp_rght(stp_rght), .busy(busy), .solved(solved), .fail(fail), .mv_cnt(mv_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Behavioural model. Headings are compass indices 0..3 = N,W,S,E so a left
  // turn is +1, a right turn +3 and an about-turn +2 (mod 4).
  localparam int P_IDLE = 0, P_GO = 1, P_MOVING = 2, P_DECIDE = 3,
                 P_TURN_GO = 4, P_TURNING = 5, P_FAILED = 6;
  logic [11:0] hdg_tab [4];
  int m_ph = P_IDLE, m_hidx = 0, m_cnt = 0, m_wait = 0;
  logic [1:0] m_mq = 2'b00;
  bit m_solved = 1'b0;

  initial begin
    hdg_tab[0] = 12'h000; hdg_tab[1] = 12'h3FF; hdg_tab[2] = 12'h7FF; hdg_tab[3] = 12'hC00;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_ph = P_IDLE; m_hidx = 0; m_cnt = 0; m_wait = 0; m_mq = 2'b00; m_solved = 1'b0;
    end else if (cmd_md && m_ph != P_IDLE && m_ph != P_FAILED) begin
      m_ph = P_IDLE;
    end else begin
      case (m_ph)
        P_IDLE: if (!cmd_md) begin
          m_ph = P_GO; m_mq = mode; m_cnt = 0; m_solved = 1'b0;
        end
        P_GO, P_TURN_GO: begin
          m_ph = (m_ph == P_GO) ? P_MOVING : P_TURNING;
          m_wait = 0;
        end
        P_MOVING, P_TURNING: begin
          if (mv_cmplt) begin
            if (m_ph == P_MOVING) begin
              m_ph = P_DECIDE;
              if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
            end else begin
              m_ph = P_GO;
            end
          end else begin
            m_wait = m_wait + 1;
            if (m_wait == TMO) m_ph = P_FAILED;
          end
        end
        P_DECIDE: begin
          if (sol_cmplt) begin
            m_ph = P_IDLE; m_solved = 1'b1;
          end else if (m_cnt >= MAXM) begin
            m_ph = P_FAILED;
          end else if (m_mq[1] && frnt_opn) begin
            m_ph = P_GO;
          end else begin
            if (m_mq[0]) m_hidx = (m_hidx + (lft_opn ? 1 : rght_opn ? 3 : 2)) % 4;
            else         m_hidx = (m_hidx + (rght_opn ? 3 : lft_opn ? 1 : 2)) % 4;
            m_ph = P_TURN_GO;
          end
        end
        P_FAILED: if (cmd_md) m_ph = P_IDLE;
        default: m_ph = P_IDLE;
      endcase
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("m_strt_mv",   32'(strt_mv),   32'(m_ph == P_GO));
      cmp("m_strt_hdng", 32'(strt_hdng), 32'(m_ph == P_TURN_GO));
      cmp("m_dsrd_hdng", 32'(dsrd_hdng), 32'(hdg_tab[m_hidx]));
      cmp("m_stp_lft",   32'(stp_lft),   32'(m_mq[0]));
      cmp("m_stp_rght",  32'(stp_rght),  32'(!m_mq[0]));
      cmp("m_busy",      32'(busy),      32'(m_ph != P_IDLE && m_ph != P_FAILED));
      cmp("m_fail",      32'(fail),      32'(m_ph == P_FAILED));
      cmp("m_solved",    32'(solved),    32'(m_solved));
      cmp("m_mv_cnt",    32'(mv_cnt),    32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From the launch cycle of a move: complete the move, take the turn, finish it.
  task automatic turn_move();
    tick(); mv_cmplt = 1'b1;
    tick(); mv_cmplt = 1'b0;
    tick();
    tick(); mv_cmplt = 1'b1;
    tick(); mv_cmplt = 1'b0;
  endtask

  initial begin
    int w;
    int mvp, cmdp;
    rst = 1'b1; cmd_md = 1'b1; mode = 2'b00; frnt_opn = 1'b0; lft_opn = 1'b0;
    rght_opn = 1'b0; mv_cmplt = 1'b0; sol_cmplt = 1'b0;
    tick(); tick();
    chk_on = 1'b1;
    cmp("rst_dsrd", 32'(dsrd_hdng), 32'h000);
    cmp("rst_cnt", 32'(mv_cnt), 0);
    cmp("rst_stp_rght", 32'(stp_rght), 1);
    cmp("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();

    // Start with left affinity; first decision turns left N->W.
    mode = 2'b01; cmd_md = 1'b0;
    tick();
    cmp("t1_strt_mv", 32'(strt_mv), 1);
    cmp("t1_stp_lft", 32'(stp_lft), 1);
    tick();
    cmp("t1_wait", 32'(strt_mv), 0);
    mv_cmplt = 1'b1; lft_opn = 1'b1;
    tick(); mv_cmplt = 1'b0;
    cmp("t1_no_hdng_yet", 32'(strt_hdng), 0);
    tick();
    cmp("t1_strt_hdng", 32'(strt_hdng), 1);
    cmp("t1_hdng_w", 32'(dsrd_hdng), 32'h3FF);
    tick(); mv_cmplt = 1'b1;
    tick(); mv_cmplt = 1'b0;
    tick(); mv_cmplt = 1'b1;
    tick(); mv_cmplt = 1'b0;
    tick();
    cmp("t1_hdng_s", 32'(dsrd_hdng), 32'h7FF);
    tick();
    // Abort while waiting on the heading change.
    cmd_md = 1'b1;
    tick();
    cmp("abort_busy", 32'(busy), 0);
    cmp("abort_hdng", 32'(dsrd_hdng), 32'h7FF);
    cmp("abort_cnt", 32'(mv_cnt), 2);

    // Right affinity from S: right open -> W, then all closed -> E.
    mode = 2'b00; cmd_md = 1'b0; lft_opn = 1'b0; rght_opn = 1'b1;
    tick();
    cmp("t2_cnt_clr", 32'(mv_cnt), 0);
    tick(); mv_cmplt = 1'b1;
    tick(); mv_cmplt = 1'b0;
    tick();
    cmp("t2_hdng_w", 32'(dsrd_hdng), 32'h3FF);
    tick(); mv_cmplt = 1'b1;
    tick(); mv_cmplt = 1'b0;
    tick(); rght_opn = 1'b0; mv_cmplt = 1'b1;
    tick(); mv_cmplt = 1'b0;
    tick();
    cmp("t2_hdng_e", 32'(dsrd_hdng), 32'hC00);
    tick(); cmd_md = 1'b1;
    tick();

    // Straight-first: front open means no turn; then solve.
    mode = 2'b11; cmd_md = 1'b0;
    tick();
    tick(); frnt_opn = 1'b1; lft_opn = 1'b1; mv_cmplt = 1'b1;
    tick(); mv_cmplt = 1'b0;
    tick();
    cmp("t3_strt_mv", 32'(strt_mv), 1);
    cmp("t3_no_hdng", 32'(strt_hdng), 0);
    cmp("t3_hdng_held", 32'(dsrd_hdng), 32'hC00);
    tick(); mv_cmplt = 1'b1;
    tick(); mv_cmplt = 1'b0; sol_cmplt = 1'b1;
    tick(); sol_cmplt = 1'b0; cmd_md = 1'b1;
    cmp("t3_solved", 32'(solved), 1);
    cmp("t3_busy", 32'(busy), 0);
    cmp("t3_cnt", 32'(mv_cnt), 2);
    frnt_opn = 1'b0; lft_opn = 1'b0;
    tick();

    // Move budget of 3 runs out at the third decision.
    mode = 2'b00; rght_opn = 1'b1; cmd_md = 1'b0;
    tick();
    cmp("t4_solved_clr", 32'(solved), 0);
    turn_move();
    turn_move();
    tick(); mv_cmplt = 1'b1;
    tick(); mv_cmplt = 1'b0;
    tick();
    cmp("t4_fail", 32'(fail), 1);
    cmp("t4_busy", 32'(busy), 0);
    cmp("t4_cnt", 32'(mv_cnt), 3);
    cmd_md = 1'b1;
    tick();
    cmp("t4_fail_clr", 32'(fail), 0);

    // Timeout: no completion after launching a move.
    cmd_md = 1'b0;
    tick();
    w = 0;
    for (int i = 0; i < 40 && !fail; i++) begin
      tick();
      if (busy) w++;
    end
    cmp("t5_fail", 32'(fail), 1);
    cmp("t5_wait_cycles", 32'(w), TMO);
    cmd_md = 1'b1;
    tick();

    // Reset in the middle of a move.
    mode = 2'b11; cmd_md = 1'b0;
    tick();
    tick(); frnt_opn = 1'b1; mv_cmplt = 1'b1;
    tick(); mv_cmplt = 1'b0;
    tick();
    tick();
    cmp("t6_cnt_pre", 32'(mv_cnt), 1);
    rst = 1'b1;
    tick(); rst = 1'b0; cmd_md = 1'b1; frnt_opn = 1'b0;
    cmp("t6_busy", 32'(busy), 0);
    cmp("t6_cnt", 32'(mv_cnt), 0);
    cmp("t6_hdng", 32'(dsrd_hdng), 32'h000);
    cmp("t6_stp_lft", 32'(stp_lft), 0);

    // Randomized traffic in segments with differing completion/abort rates.
    for (int seg = 0; seg < 16; seg++) begin
      case ($urandom_range(0, 3))
        0: mvp = 0;
        1: mvp = 4;
        2: mvp = 30;
        default: mvp = 60;
      endcase
      cmdp = ($urandom_range(0, 1) != 0) ? 2 : 10;
      repeat (200) begin
        rst       = ($urandom_range(0, 299) == 0);
        cmd_md    = ($urandom_range(0, 99) < cmdp);
        mode      = 2'($urandom_range(0, 3));
        frnt_opn  = 1'($urandom_range(0, 1));
        lft_opn   = 1'($urandom_range(0, 1));
        rght_opn  = 1'($urandom_range(0, 1));
        mv_cmplt  = ($urandom_range(0, 99) < mvp);
        sol_cmplt = ($urandom_range(0, 99) < 15);
        tick();
      end
    end
    rst = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
